// File: rtl/pvp_result_sequencer.sv
// pvp_result_sequencer: sequences the PvP end-of-game display (win animation,
// result overlay hold, continue acknowledge) between the game FSM and the
// animation/overlay datapath.
// Optional feature macro: PVP_SCORE_TALLY_EN adds saturating x_wins/o_wins tallies.
module pvp_result_sequencer #(
  parameter int unsigned CLK_HZ          = 100_000_000,
  parameter int unsigned HOLD_MS         = 2000,
  parameter int unsigned ANIM_TIMEOUT_MS = 4000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] result,
  input  logic       result_valid,
  input  logic       anim_done_x,
  input  logic       anim_done_o,
  input  logic       btn_continue,
  output logic       anim_start_x,
  output logic       anim_start_o,
  output logic       show_result,
  output logic       winner,
  output logic       is_draw,
  output logic       busy,
`ifdef PVP_SCORE_TALLY_EN
  output logic [3:0] x_wins,
  output logic [3:0] o_wins,
`endif
  output logic       seq_done
);

  localparam int unsigned DIV   = (CLK_HZ / 1000 < 1) ? 1 : CLK_HZ / 1000;
  localparam int unsigned PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned MS_W  = 13;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ANIM     = 2'd1,
    S_HOLD     = 2'd2,
    S_WAIT_ACK = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              winner_d, draw_d;
  logic              start_x_d, start_o_d, show_d, busy_d, seq_done_d;
  logic [PRE_W-1:0]  presc_q;
  logic [MS_W-1:0]   ms_q;
  logic              tick_c, entry_c, anim_timeout_c, hold_expired_c, sel_done_c;

  // 1 ms tick and elapsed-time compares; both counters restart on state entry
  assign tick_c         = (presc_q == PRE_W'(DIV - 1));
  assign entry_c        = (state_d != state_q);
  assign anim_timeout_c = tick_c && (ms_q == MS_W'(ANIM_TIMEOUT_MS - 1));
  assign hold_expired_c = tick_c && (ms_q == MS_W'(HOLD_MS - 1));
  assign sel_done_c     = winner ? anim_done_o : anim_done_x;

  // Next-state, latched result and next registered output values
  always_comb begin
    state_d  = state_q;
    winner_d = winner;
    draw_d   = is_draw;
    case (state_q)
      S_IDLE: begin
        if (result_valid) begin
          case (result)
            2'b01: begin winner_d = 1'b0; draw_d = 1'b0; state_d = S_ANIM; end
            2'b10: begin winner_d = 1'b1; draw_d = 1'b0; state_d = S_ANIM; end
            2'b11: begin winner_d = 1'b0; draw_d = 1'b1; state_d = S_HOLD; end
            default: ;
          endcase
        end
      end
      S_ANIM: begin
        if (sel_done_c || anim_timeout_c) state_d = S_HOLD;
      end
      S_HOLD: begin
        if (hold_expired_c) state_d = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (btn_continue) begin
          state_d  = S_IDLE;
          winner_d = 1'b0;
          draw_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Start stays asserted through HOLD/WAIT_ACK so the animation holds its last frame
    start_x_d  = (state_d != S_IDLE) && !draw_d && !winner_d;
    start_o_d  = (state_d != S_IDLE) && !draw_d &&  winner_d;
    show_d     = (state_d == S_HOLD) || (state_d == S_WAIT_ACK);
    busy_d     = (state_d != S_IDLE);
    seq_done_d = (state_q == S_WAIT_ACK) && (state_d == S_IDLE);
  end

  // State, latched result and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      winner       <= 1'b0;
      is_draw      <= 1'b0;
      anim_start_x <= 1'b0;
      anim_start_o <= 1'b0;
      show_result  <= 1'b0;
      busy         <= 1'b0;
      seq_done     <= 1'b0;
    end else begin
      state_q      <= state_d;
      winner       <= winner_d;
      is_draw      <= draw_d;
      anim_start_x <= start_x_d;
      anim_start_o <= start_o_d;
      show_result  <= show_d;
      busy         <= busy_d;
      seq_done     <= seq_done_d;
    end
  end

  // Prescaler and millisecond counter, cleared on every state entry
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_q <= '0;
      ms_q    <= '0;
    end else if (entry_c) begin
      presc_q <= '0;
      ms_q    <= '0;
    end else begin
      presc_q <= tick_c ? '0 : presc_q + PRE_W'(1);
      if (tick_c && (ms_q != {MS_W{1'b1}})) ms_q <= ms_q + MS_W'(1);
    end
  end

`ifdef PVP_SCORE_TALLY_EN
  // Saturating win tallies, bumped on IDLE->ANIM; only reset clears them
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_wins <= 4'd0;
      o_wins <= 4'd0;
    end else if ((state_q == S_IDLE) && (state_d == S_ANIM)) begin
      if (!winner_d && (x_wins != 4'hF)) x_wins <= x_wins + 4'd1;
      if ( winner_d && (o_wins != 4'hF)) o_wins <= o_wins + 4'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pvp_result_sequencer.sv
// Scoreboard bench for pvp_result_sequencer (CLK_HZ=1000 so 1 ms = 1 cycle).
// Stimulus pushes {cycle, expected outputs}; the monitor pops on every output
// change or scheduled check cycle.
module tb_pvp_result_sequencer;

  localparam int unsigned CLK_HZ          = 1000;
  localparam int unsigned HOLD_MS         = 2;
  localparam int unsigned ANIM_TIMEOUT_MS = 3;
`ifdef PVP_SCORE_TALLY_EN
  localparam bit TALLY = 1'b1;
`else
  localparam bit TALLY = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] result = 2'b00;
  logic       result_valid = 1'b0;
  logic       anim_done_x = 1'b0;
  logic       anim_done_o = 1'b0;
  logic       btn_continue = 1'b0;
  logic       anim_start_x, anim_start_o, show_result, winner, is_draw, busy, seq_done;
  logic [3:0] xw_dut, ow_dut;

  pvp_result_sequencer #(
    .CLK_HZ(CLK_HZ), .HOLD_MS(HOLD_MS), .ANIM_TIMEOUT_MS(ANIM_TIMEOUT_MS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .result(result), .result_valid(result_valid),
    .anim_done_x(anim_done_x), .anim_done_o(anim_done_o), .btn_continue(btn_continue),
    .anim_start_x(anim_start_x), .anim_start_o(anim_start_o), .show_result(show_result),
    .winner(winner), .is_draw(is_draw), .busy(busy),
`ifdef PVP_SCORE_TALLY_EN
    .x_wins(xw_dut), .o_wins(ow_dut),
`endif
    .seq_done(seq_done)
  );

`ifndef PVP_SCORE_TALLY_EN
  assign xw_dut = 4'd0;
  assign ow_dut = 4'd0;
`endif

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [14:0] outs;
  assign outs = {xw_dut, ow_dut, anim_start_x, anim_start_o, show_result, winner, is_draw, busy, seq_done};

  // Scoreboard
  int          qc[$];
  logic [14:0] qv[$];
  string       qn[$];
  int          tests = 0;
  int          fails = 0;
  bit          mon_en = 1'b0;
  logic [14:0] prev;
  int          ec;
  logic [14:0] ev;
  string       en;

  // Reference tally model
  logic [3:0] xw = 4'd0;
  logic [3:0] ow = 4'd0;

  function automatic logic [3:0] inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  function automatic logic [14:0] mk(input logic [3:0] tx, input logic [3:0] to,
                                     input logic sx, input logic so, input logic sh,
                                     input logic w, input logic d, input logic b,
                                     input logic sd);
    return {tx, to, sx, so, sh, w, d, b, sd};
  endfunction

  task automatic push(input int c, input logic [14:0] v, input string n);
    qc.push_back(c);
    qv.push_back(v);
    qn.push_back(n);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: compare whenever outputs change or a check is scheduled for this cycle
  always @(negedge clk) begin
    if (mon_en && ((outs !== prev) || ((qc.size() > 0) && (qc[0] == cyc)))) begin
      tests++;
      if (qc.size() == 0) begin
        fails++;
        $display("FAIL unexpected_change cyc=%0d got=%h", cyc, outs);
      end else begin
        ec = qc.pop_front();
        ev = qv.pop_front();
        en = qn.pop_front();
        if ((ec != cyc) || (ev !== outs)) begin
          fails++;
          $display("FAIL %s: cyc=%0d got=%h, expected %h at cyc %0d", en, cyc, outs, ev, ec);
        end
      end
    end
    prev = outs;
  end

  // Full win sequence ending on done flag; also probes the ignored
  // non-selected done and continue presses during HOLD.
  task automatic win_seq(input bit is_o);
    int c;
    c = cyc;
    if (TALLY) begin
      if (is_o) ow = inc4(ow); else xw = inc4(xw);
    end
    push(c + 1, mk(xw, ow, !is_o, is_o, 1'b0, is_o, 1'b0, 1'b1, 1'b0), "win_start");
    result = is_o ? 2'b10 : 2'b01;
    result_valid = 1'b1;
    step(1);
    result_valid = 1'b0;
    if (is_o) anim_done_x = 1'b1; else anim_done_o = 1'b1;
    step(1);
    anim_done_x = !is_o;
    anim_done_o = is_o;
    push(c + 3, mk(xw, ow, !is_o, is_o, 1'b1, is_o, 1'b0, 1'b1, 1'b0), "win_overlay");
    step(1);
    anim_done_x = 1'b0;
    anim_done_o = 1'b0;
    btn_continue = 1'b1;
    step(2);
    push(c + 6, mk(xw, ow, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), "win_release");
    push(c + 7, mk(xw, ow, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "win_idle");
    step(1);
    btn_continue = 1'b0;
    step(2);
  endtask

  initial begin
    int c;
    // Reset state
    step(3);
    push(cyc, 15'd0, "reset_state");
    mon_en = 1'b1;
    rst_n = 1'b1;
    step(2);

    // X win through done flag
    win_seq(1'b0);

    // result 00 strobe is ignored
    c = cyc;
    push(c + 1, mk(xw, ow, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "result_none");
    result = 2'b00;
    result_valid = 1'b1;
    step(1);
    result_valid = 1'b0;
    step(2);

    // Draw: straight to HOLD, stray strobe and continue ignored in HOLD
    c = cyc;
    push(c + 1, mk(xw, ow, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0), "draw_hold");
    result = 2'b11;
    result_valid = 1'b1;
    step(1);
    result = 2'b01;
    btn_continue = 1'b1;
    step(1);
    result_valid = 1'b0;
    step(1);
    push(c + 4, mk(xw, ow, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), "draw_release");
    push(c + 5, mk(xw, ow, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "draw_idle");
    step(1);
    btn_continue = 1'b0;
    step(2);

    // O win via timeout (X done ignored), then continue + strobe together
    c = cyc;
    if (TALLY) ow = inc4(ow);
    push(c + 1, mk(xw, ow, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0), "tmo_start");
    result = 2'b10;
    result_valid = 1'b1;
    step(1);
    result_valid = 1'b0;
    anim_done_x = 1'b1;
    push(c + 4, mk(xw, ow, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0), "tmo_hold");
    step(3);
    anim_done_x = 1'b0;
    step(2);
    btn_continue = 1'b1;
    result = 2'b01;
    result_valid = 1'b1;
    push(c + 7, mk(xw, ow, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), "simul_release");
    push(c + 8, mk(xw, ow, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "simul_strobe_dropped");
    step(1);
    btn_continue = 1'b0;
    result_valid = 1'b0;
    step(3);

    // O win through done flag
    win_seq(1'b1);

    // Reset mid-ANIM clears everything including tallies
    c = cyc;
    if (TALLY) xw = inc4(xw);
    push(c + 1, mk(xw, ow, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0), "rst_anim_start");
    result = 2'b01;
    result_valid = 1'b1;
    step(1);
    result_valid = 1'b0;
    rst_n = 1'b0;
    xw = 4'd0;
    ow = 4'd0;
    push(c + 2, 15'd0, "rst_mid_anim");
    step(1);
    rst_n = 1'b1;
    step(2);

    // Repeated X wins (saturates the X tally when present)
    for (int i = 0; i < (TALLY ? 16 : 2); i++) win_seq(1'b0);

    step(3);
    tests++;
    if (qc.size() != 0) begin
      fails++;
      $display("FAIL pending_expectations: got %0d left, expected 0", qc.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
